// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command front-end for the 8-bit ALU.
// Latches one operation, holds the ALU inputs for a per-op settle interval,
// captures result/carry/zero, and presents them on a valid/ready response port.
module alu_cmd_sequencer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned SETTLE     = 1,
    parameter int unsigned SHIFT_WAIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_shift,
    output logic [2:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_shift,
    input  logic [WIDTH-1:0] alu_o,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic [2:0]       rsp_op,
    output logic [15:0]      done_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_RESP
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_SHIFT = 3'b011;

    // Settle counter preloads: the capture edge is the one on which the
    // counter reads zero, so a load of N-1 gives exactly N DRIVE cycles.
    localparam logic [3:0] CNT_COMB  = 4'(SETTLE - 1);
    localparam logic [3:0] CNT_SHIFT = 4'(SETTLE + SHIFT_WAIT - 1);

    state_t     state;
    logic [3:0] cnt;

    // Sequencer FSM: accept, settle, capture, respond; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cmd_ready  <= 1'b0;
            alu_sel    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_shift  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_cout   <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_op     <= '0;
            done_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        alu_sel   <= cmd_op;
                        alu_a     <= cmd_a;
                        alu_b     <= cmd_b;
                        alu_shift <= cmd_shift;
                        cnt       <= (cmd_op == OP_SHIFT) ? CNT_SHIFT : CNT_COMB;
                        cmd_ready <= 1'b0;
                        state     <= ST_DRIVE;
                    end else begin
                        // Also the path that raises cmd_ready on the first edge after reset.
                        cmd_ready <= 1'b1;
                    end
                end

                ST_DRIVE: begin
                    if (cnt == 4'd0) begin
                        rsp_data  <= alu_o;
                        rsp_cout  <= ((alu_sel == OP_ADD) || (alu_sel == OP_SUB)) ? alu_cout : 1'b0;
                        rsp_zero  <= (alu_o == '0);
                        rsp_op    <= alu_sel;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        done_count <= done_count + 16'd1;
                        // Ready for the next command in the cycle right after the handshake.
                        cmd_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed bench with a behavioural ALU (including a
// one-clock shifter) and hand-computed expected responses.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_shift;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a, cmd_b;
    logic [2:0]  alu_sel;
    logic [7:0]  alu_a, alu_b, alu_o;
    logic        alu_shift, alu_cout;
    logic        rsp_valid, rsp_ready, rsp_cout, rsp_zero;
    logic [7:0]  rsp_data;
    logic [2:0]  rsp_op;
    logic [15:0] done_count;

    logic        force_cout;
    logic [7:0]  sh_q;
    logic        sh_c;
    logic [8:0]  t9;
    logic [15:0] t16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .WIDTH     (8),
        .SETTLE    (1),
        .SHIFT_WAIT(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_shift (cmd_shift),
        .alu_sel   (alu_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_shift (alu_shift),
        .alu_o     (alu_o),
        .alu_cout  (alu_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_cout  (rsp_cout),
        .rsp_zero  (rsp_zero),
        .rsp_op    (rsp_op),
        .done_count(done_count)
    );

    // Clocked shifter: result lags the driven operand by one clock.
    always_ff @(posedge clk) begin
        sh_q <= alu_shift ? {1'b0, alu_a[7:1]} : {alu_a[6:0], 1'b0};
        sh_c <= alu_shift ? alu_a[0] : alu_a[7];
    end

    // Combinational ALU model; force_cout lets a test drive carry high.
    always_comb begin
        alu_o    = '0;
        alu_cout = 1'b0;
        t9       = '0;
        t16      = '0;
        case (alu_sel)
            3'd0: begin t9 = {1'b0, alu_a} + {1'b0, alu_b}; alu_o = t9[7:0]; alu_cout = t9[8]; end
            3'd1: begin t9 = {1'b0, alu_a} - {1'b0, alu_b}; alu_o = t9[7:0]; alu_cout = t9[8]; end
            3'd2: begin t16 = 16'(alu_a) * 16'(alu_b); alu_o = t16[7:0]; alu_cout = |t16[15:8]; end
            3'd3: begin alu_o = sh_q; alu_cout = sh_c; end
            3'd4: alu_o = alu_a | alu_b;
            3'd5: alu_o = ~alu_a;
            3'd6: alu_o = alu_a ^ alu_b;
            default: alu_o = ~(alu_a & alu_b);
        endcase
        alu_cout = alu_cout | force_cout;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 32'({cmd_ready, rsp_valid, rsp_cout, rsp_zero, alu_shift}), 0);
        check({tag, "_rsp"}, 32'({rsp_op, rsp_data}), 0);
        check({tag, "_alu"}, 32'({alu_sel, alu_a, alu_b}), 0);
        check({tag, "_cnt"}, 32'(done_count), 0);
    endtask

    // Present a command and step through its accept edge.
    task automatic issue(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic sh);
        check({tag, "_rdy"}, 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_shift = sh;
        step();
        cmd_valid = 1'b0;
        check({tag, "_acc"}, 32'({cmd_ready, alu_sel, alu_a, alu_b, alu_shift}),
              32'({1'b0, op, a, b, sh}));
    endtask

    // Bounded wait for rsp_valid; checks the number of cycles after accept.
    task automatic wait_rsp(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic check_rsp(input string tag, input logic [7:0] data, input logic cout,
                             input logic zero, input logic [2:0] op);
        check({tag, "_rsp"}, 32'({rsp_valid, rsp_data, rsp_cout, rsp_zero, rsp_op}),
              32'({1'b1, data, cout, zero, op}));
    endtask

    task automatic handshake(input string tag, input int exp_count);
        rsp_ready = 1'b1;
        step();
        check({tag, "_hs"}, 32'({rsp_valid, cmd_ready}), 32'(2'b01));
        check({tag, "_done"}, 32'(done_count), 32'(exp_count));
    endtask

    initial begin
        int n;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_a      = '0;
        cmd_b      = '0;
        cmd_shift  = 1'b0;
        rsp_ready  = 1'b1;
        force_cout = 1'b0;

        // Reset values, and cmd_ready stays low while reset is held.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst0");
        step();
        check("rst_hold_rdy", 32'(cmd_ready), 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("rst_rel_rdy", 32'(cmd_ready), 1);

        // Add F0+20 = 0x110.
        issue("add", 3'd0, 8'hF0, 8'h20, 1'b0);
        wait_rsp("add", 1);
        check_rsp("add", 8'h10, 1'b1, 1'b0, 3'd0);
        check("add_done_pre", 32'(done_count), 0);
        handshake("add", 1);

        // Sub 5-5 = 0, no borrow.
        issue("sub", 3'd1, 8'h05, 8'h05, 1'b0);
        wait_rsp("sub", 1);
        check_rsp("sub", 8'h00, 1'b0, 1'b1, 3'd1);
        handshake("sub", 2);

        // Not 0 with carry forced high: carry must be masked.
        force_cout = 1'b1;
        issue("not", 3'd5, 8'h00, 8'h00, 1'b0);
        wait_rsp("not", 1);
        check_rsp("not", 8'hFF, 1'b0, 1'b0, 3'd5);
        handshake("not", 3);
        force_cout = 1'b0;

        // Shift right 0x81 -> 0x40, shifter carry 1 masked; capture at E+3.
        issue("shf", 3'd3, 8'h81, 8'h00, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_a     = 8'h55;
        cmd_shift = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            step();
            check("shf_drive", 32'({rsp_valid, cmd_ready, alu_sel, alu_a, alu_shift}),
                  32'({1'b0, 1'b0, 3'd3, 8'h81, 1'b1}));
        end
        step();
        cmd_valid = 1'b0;
        check_rsp("shf", 8'h40, 1'b0, 1'b0, 3'd3);
        check("shf_hold", 32'({alu_a, alu_shift}), 32'({8'h81, 1'b1}));
        handshake("shf", 4);

        // Backpressure: xor 3C^0F = 33 held while a new command is offered.
        rsp_ready = 1'b0;
        issue("bp", 3'd6, 8'h3C, 8'h0F, 1'b0);
        wait_rsp("bp", 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_a     = 8'h11;
        cmd_b     = 8'h22;
        for (int i = 0; i < 5; i++) begin
            step();
            check_rsp("bp_hold", 8'h33, 1'b0, 1'b0, 3'd6);
            check("bp_alu", 32'({cmd_ready, alu_sel, alu_a, alu_b}), 32'({1'b0, 3'd6, 8'h3C, 8'h0F}));
        end
        check("bp_done", 32'(done_count), 4);
        handshake("bp", 5);
        step();
        cmd_valid = 1'b0;
        check("bp_next_acc", 32'({cmd_ready, alu_sel, alu_a, alu_b}), 32'({1'b0, 3'd0, 8'h11, 8'h22}));
        wait_rsp("bp_next", 1);
        check_rsp("bp_next", 8'h33, 1'b0, 1'b0, 3'd0);
        handshake("bp_next", 6);

        // Reset mid-DRIVE (shift gives three DRIVE cycles).
        issue("rd", 3'd3, 8'h81, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_drv");
        @(negedge clk) rst_n = 1'b1;
        step();
        check("rst_drv_rdy", 32'(cmd_ready), 1);
        issue("rd_fresh", 3'd2, 8'h10, 8'h11, 1'b0);
        wait_rsp("rd_fresh", 1);
        check_rsp("rd_fresh", 8'h10, 1'b0, 1'b0, 3'd2);
        handshake("rd_fresh", 1);

        // Reset mid-RESP with response pending.
        rsp_ready = 1'b0;
        issue("rr", 3'd7, 8'hFF, 8'hFF, 1'b0);
        wait_rsp("rr", 1);
        check_rsp("rr", 8'h00, 1'b0, 1'b1, 3'd7);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_rsp");
        @(negedge clk) rst_n = 1'b1;
        step();
        check("rst_rsp_rdy", 32'(cmd_ready), 1);
        issue("rr_fresh", 3'd4, 8'hA0, 8'h05, 1'b0);
        wait_rsp("rr_fresh", 1);
        check_rsp("rr_fresh", 8'hA5, 1'b0, 1'b0, 3'd4);
        handshake("rr_fresh", 1);

        // 65536 back-to-back xor commands from a fresh reset: done_count wraps.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 3'd6;
        cmd_a     = 8'hFF;
        cmd_b     = 8'h0F;
        n = 0;
        for (int c = 0; c < 230000 && n < 65536; c++) begin
            step();
            if (rsp_valid) n++;
        end
        check("wrap_rsps", 32'(n), 65536);
        check_rsp("wrap_last", 8'hF0, 1'b0, 1'b0, 3'd6);
        check("wrap_pre", 32'(done_count), 32'hFFFF);
        cmd_valid = 1'b0;
        step();
        check("wrap_done", 32'(done_count), 0);
        check("wrap_idle", 32'({rsp_valid, cmd_ready}), 32'(2'b01));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side initiator for the 8-bit ALU datapath. It accepts one operation at a time over a valid/ready command port and drives the ALU's select, operand and shift inputs. After a per-operation settle interval it captures the ALU result and carry, and returns result, carry and zero flag over a valid/ready response port. It sits between any upstream controller (bus slave, test sequencer) and the ALU instance, and provides the handshake and timing discipline that the ALU itself does not have.

## Interface
Parameters:
- WIDTH, 8: operand and result width.
- SETTLE, 1: DRIVE cycles for combinational ops; legal range 1 to 15.
- SHIFT_WAIT, 1: extra DRIVE cycles for the clocked shift op; legal range 0 to 15. SETTLE+SHIFT_WAIT must not exceed 15.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  000 add, 001 sub, 010 mul, 011 shift, 100 or, 101 not, 110 xor, 111 nand.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_shift  in  1  shift direction/control, passed to the ALU.
- alu_sel  out  3  ALU operation select; equals the latched cmd_op.
- alu_a  out  WIDTH  driven operand A.
- alu_b  out  WIDTH  driven operand B.
- alu_shift  out  1  driven shift control.
- alu_o  in  WIDTH  ALU result.
- alu_cout  in  1  ALU carry/borrow.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  downstream accepts the response.
- rsp_data  out  WIDTH  captured result.
- rsp_cout  out  1  captured carry; forced to 0 for every op except add and sub.
- rsp_zero  out  1  1 when the captured result equals 0.
- rsp_op  out  3  opcode of the response.
- done_count  out  16  count of completed response handshakes; wraps from 0xFFFF to 0.

## Operation
- FSM has three states: IDLE, DRIVE, RESP. Reset state is IDLE.
- IDLE: cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op/a/b/shift into the alu_* registers.
  - Load the settle counter with SETTLE-1, or SETTLE+SHIFT_WAIT-1 when op=011.
  - Go to DRIVE.
- DRIVE: cmd_ready=0 and alu_* are held.
  - Decrement the counter each cycle.
  - On the cycle the counter is 0, capture alu_o into rsp_data, alu_cout (add/sub only) into rsp_cout, (alu_o==0) into rsp_zero, and alu_sel into rsp_op.
  - Go to RESP on that same edge.
- RESP: rsp_valid=1, cmd_ready=0.
  - rsp_* and alu_* are held stable until rsp_valid&&rsp_ready.
  - On that handshake: increment done_count, deassert rsp_valid, go to IDLE.
- cmd_valid is ignored outside IDLE. There is no queuing, and the next accept cannot happen before the cycle after the response handshake.
- alu_* keep their last values in IDLE. They change only on command accept.
- The upstream side may change cmd_* freely while cmd_ready=0.
- Reset asserted in any state returns the FSM to IDLE immediately. Any in-flight op and its pending response are discarded, and no done_count increment occurs.

## Timing
- Reset values:
  - cmd_ready=0; it rises on the first clk edge after rst_n deasserts (registered).
  - alu_sel=0, alu_a=0, alu_b=0, alu_shift=0.
  - rsp_valid=0, rsp_data=0, rsp_cout=0, rsp_zero=0, rsp_op=0.
  - done_count=0.
- Accept happens at edge E. alu_* are valid from E onward.
- The capture edge is E+SETTLE for combinational ops and E+SETTLE+SHIFT_WAIT for shift.
- rsp_valid is high in the cycle after the capture edge and stays high until the handshake edge.
- Minimum command-to-command period is SETTLE+2 cycles (combinational op, rsp_ready held high).
- All outputs are registered. No combinational path exists from cmd_* or alu_* inputs to any output.

## Test plan
- Defaults. Add A=0xF0, B=0x20, rsp_ready=1, accepted at edge E → rsp_valid high after edge E+1, rsp_data=0x10, rsp_cout=1, rsp_zero=0, rsp_op=000, done_count=1.
- Sub A=0x05, B=0x05 → rsp_data=0x00, rsp_zero=1. Not A=0x00 with alu_cout stimulated to 1 → rsp_data=0xFF, rsp_cout=0.
- SHIFT_WAIT=2. Shift A=0x81 against a clocked shifter model → capture at E+3, rsp_valid first high after edge E+3. alu_a=0x81 and alu_shift stay stable throughout DRIVE.
- Backpressure: hold rsp_ready=0 for 5 cycles, with cmd_valid=1 and new operands presented → rsp_* and alu_* are unchanged, cmd_ready=0, no second accept. Raise rsp_ready → handshake, IDLE next cycle, then the new command is accepted.
- Reset mid-DRIVE and mid-RESP → all outputs return to their reset values asynchronously and done_count is unchanged from 0. After release, cmd_ready=1 on the first edge and a fresh op completes normally.
- Issue 65536 back-to-back xor commands → done_count wraps to 0x0000.
